// File: rtl/cpu_pkg.sv
// Shared CPU types for the 16-bit ALU sequencing stage.
// Op codes, writeback targets, sequencer states, flag bit positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD_HL_RR   = 3'd0,
    OP_INC_RR      = 3'd1,
    OP_DEC_RR      = 3'd2,
    OP_ADD_SP_E8   = 3'd3,
    OP_LD_HL_SP_E8 = 3'd4
  } alu16_op_t;

  typedef enum logic [1:0] {
    WB_HL = 2'd0,
    WB_SP = 2'd1,
    WB_RR = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IMM   = 3'd1,
    S_CALC  = 3'd2,
    S_INT1  = 3'd3,
    S_INT2  = 3'd4,
    S_WRITE = 3'd5
  } seq_state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  localparam logic [15:0] INC_CONST = 16'h0001;
  localparam logic [15:0] DEC_CONST = 16'hFFFF;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/alu16_sequencer.sv
// M-cycle sequencer around the CPU's shared 16-bit adder.
// Drives operands, captures sum/flags, schedules writeback.
module alu16_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_tick,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] rr_val,
  input  logic [15:0] hl_val,
  input  logic [15:0] sp_val,
  input  logic [7:0]  imm8,
  input  logic        imm_valid,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_ctrl,
  input  logic [15:0] add_y,
  input  logic [3:0]  add_f,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [1:0]  wb_sel,
  output logic [15:0] wb_data,
  output logic        flag_we,
  output logic [3:0]  flag_mask,
  output logic [3:0]  flag_val
);

  seq_state_t  r_state;
  alu16_op_t   r_op;
  logic [15:0] r_rr;
  logic [15:0] r_hl;
  logic [15:0] r_sp;
  logic [7:0]  r_imm;
  logic [15:0] r_res;
  logic        r_h;
  logic        r_c;
  logic [15:0] r_hold_a;
  logic [15:0] r_hold_b;
  logic        r_hold_ctrl;

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic        w_ctrl;
  logic        w_calc;
  logic        w_valid_op;
  logic        w_sp_op;
  logic        w_unused;

  assign w_valid_op = (op <= 3'd4);
  assign w_sp_op    = (op == 3'd3) || (op == 3'd4);
  assign w_calc     = (r_state == S_CALC);
  assign w_unused   = &{1'b0, add_f[3:2]};

  // Operand selection from the latched instruction context
  always_comb begin
    w_a    = r_rr;
    w_b    = INC_CONST;
    w_ctrl = 1'b0;
    case (r_op)
      OP_ADD_HL_RR: begin
        w_a    = r_hl;
        w_b    = r_rr;
        w_ctrl = 1'b1;
      end
      OP_INC_RR: w_b = INC_CONST;
      OP_DEC_RR: w_b = DEC_CONST;
      default: begin
        w_a = r_sp;
        w_b = sext8(r_imm);
      end
    endcase
  end

  // Adder sees live operands in CALC, last driven values otherwise
  assign add_a    = w_calc ? w_a    : r_hold_a;
  assign add_b    = w_calc ? w_b    : r_hold_b;
  assign add_ctrl = w_calc ? w_ctrl : r_hold_ctrl;

  // Remember the operands last presented to the adder
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_a    <= '0;
      r_hold_b    <= '0;
      r_hold_ctrl <= 1'b0;
    end else if (w_calc) begin
      r_hold_a    <= w_a;
      r_hold_b    <= w_b;
      r_hold_ctrl <= w_ctrl;
    end
  end

  // Sequencer state, operand latches and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD_HL_RR;
      r_rr    <= '0;
      r_hl    <= '0;
      r_sp    <= '0;
      r_imm   <= '0;
      r_res   <= '0;
      r_h     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && w_valid_op) begin
            r_op    <= alu16_op_t'(op);
            r_rr    <= rr_val;
            r_hl    <= hl_val;
            r_sp    <= sp_val;
            r_state <= w_sp_op ? S_IMM : S_CALC;
          end
        end
        S_IMM: begin
          if (m_tick && imm_valid) begin
            r_imm   <= imm8;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (m_tick) begin
            r_res   <= add_y;
            r_h     <= add_f[1];
            r_c     <= add_f[0];
            r_state <= (r_op == OP_ADD_SP_E8) ? S_INT1 : S_WRITE;
          end
        end
        S_INT1, S_INT2: begin
          if (m_tick) r_state <= S_WRITE;
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign wb_data = r_res;

  // Writeback and flag strobes for the single WRITE clock
  always_comb begin
    done      = 1'b0;
    wb_en     = 1'b0;
    flag_we   = 1'b0;
    wb_sel    = WB_HL;
    flag_mask = 4'b0000;
    flag_val  = 4'b0000;
    if (r_state == S_WRITE) begin
      done  = 1'b1;
      wb_en = 1'b1;
      flag_val[FLAG_H] = r_h;
      flag_val[FLAG_C] = r_c;
      case (r_op)
        OP_ADD_HL_RR: begin
          wb_sel            = WB_HL;
          flag_we           = 1'b1;
          flag_mask[FLAG_N] = 1'b1;
          flag_mask[FLAG_H] = 1'b1;
          flag_mask[FLAG_C] = 1'b1;
        end
        OP_INC_RR, OP_DEC_RR: begin
          wb_sel   = WB_RR;
          flag_val = 4'b0000;
        end
        default: begin
          wb_sel    = (r_op == OP_ADD_SP_E8) ? WB_SP : WB_HL;
          flag_we   = 1'b1;
          flag_mask = 4'b1111;
          flag_mask[FLAG_Z] = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a behavioural adder.
// Each task drives one scenario and checks its own results.
module tb_alu16_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m_tick = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] rr_val = 16'h0;
  logic [15:0] hl_val = 16'h0;
  logic [15:0] sp_val = 16'h0;
  logic [7:0]  imm8 = 8'h0;
  logic        imm_valid = 1'b0;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_ctrl;
  logic [15:0] add_y;
  logic [3:0]  add_f;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [1:0]  wb_sel;
  logic [15:0] wb_data;
  logic        flag_we;
  logic [3:0]  flag_mask;
  logic [3:0]  flag_val;

  alu16_sequencer dut (
    .clk(clk), .reset_n(reset_n), .m_tick(m_tick),
    .start(start), .op(op), .rr_val(rr_val),
    .hl_val(hl_val), .sp_val(sp_val), .imm8(imm8),
    .imm_valid(imm_valid), .add_a(add_a), .add_b(add_b),
    .add_ctrl(add_ctrl), .add_y(add_y), .add_f(add_f),
    .busy(busy), .done(done), .wb_en(wb_en),
    .wb_sel(wb_sel), .wb_data(wb_data), .flag_we(flag_we),
    .flag_mask(flag_mask), .flag_val(flag_val)
  );

  always #5 clk = ~clk;

  logic [16:0] s16;
  logic [12:0] s12;
  logic [8:0]  s8;
  logic [4:0]  s4;
  assign s16 = {1'b0, add_a} + {1'b0, add_b};
  assign s12 = {1'b0, add_a[11:0]} + {1'b0, add_b[11:0]};
  assign s8  = {1'b0, add_a[7:0]} + {1'b0, add_b[7:0]};
  assign s4  = {1'b0, add_a[3:0]} + {1'b0, add_b[3:0]};
  assign add_y = s16[15:0];
  assign add_f = add_ctrl ? {2'b00, s12[12], s16[16]}
                          : {2'b00, s4[4], s8[8]};

  int checks = 0;
  int errors = 0;
  int n_done, n_wb, n_fw;
  logic [15:0] c_data;
  logic [1:0]  c_sel;
  logic [3:0]  c_mask, c_val;
  logic        c_fwe;

  task automatic clr();
    n_done = 0; n_wb = 0; n_fw = 0;
    c_data = 16'hxxxx; c_sel = 2'bxx;
    c_mask = 4'hx; c_val = 4'hx; c_fwe = 1'bx;
  endtask

  task automatic sample();
    #1;
    if (done) begin
      n_done++;
      c_data = wb_data; c_sel = wb_sel;
      c_mask = flag_mask; c_val = flag_val;
      c_fwe = flag_we;
    end
    if (wb_en) n_wb++;
    if (flag_we) n_fw++;
  endtask

  task automatic clk1(input logic t, input logic iv);
    @(negedge clk);
    start = 1'b0; m_tick = t; imm_valid = iv;
    @(posedge clk);
    sample();
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] rr,
                       input logic [15:0] hl, input logic [15:0] sp,
                       input logic t);
    @(negedge clk);
    start = 1'b1; op = o; rr_val = rr; hl_val = hl; sp_val = sp;
    m_tick = t; imm_valid = 1'b0;
    @(posedge clk);
    sample();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rst_wb_en got %b want 0", wb_en); end
    checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL rst_flag_we got %b want 0", flag_we); end
    checks++; if (wb_sel !== 2'd0) begin errors++; $display("FAIL rst_wb_sel got %h want 0", wb_sel); end
    checks++; if (wb_data !== 16'h0) begin errors++; $display("FAIL rst_wb_data got %h want 0", wb_data); end
    checks++; if (flag_mask !== 4'h0) begin errors++; $display("FAIL rst_mask got %b want 0000", flag_mask); end
    checks++; if (flag_val !== 4'h0) begin errors++; $display("FAIL rst_val got %b want 0000", flag_val); end
    checks++; if (add_a !== 16'h0) begin errors++; $display("FAIL rst_add_a got %h want 0", add_a); end
    checks++; if (add_b !== 16'h0) begin errors++; $display("FAIL rst_add_b got %h want 0", add_b); end
    checks++; if (add_ctrl !== 1'b0) begin errors++; $display("FAIL rst_add_ctrl got %b want 0", add_ctrl); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_add_hl_half();
    clr();
    issue(3'd0, 16'h0001, 16'h0FFF, 16'h0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL addhl_busy got %b want 1", busy); end
    checks++; if (add_ctrl !== 1'b1) begin errors++; $display("FAIL addhl_ctrl got %b want 1", add_ctrl); end
    clk1(1'b0, 1'b0);
    clk1(1'b0, 1'b0);
    checks++; if (n_done !== 0) begin errors++; $display("FAIL addhl_early got %0d want 0", n_done); end
    clk1(1'b1, 1'b0);
    checks++; if (n_done !== 1) begin errors++; $display("FAIL addhl_done got %0d want 1", n_done); end
    checks++; if (c_sel !== 2'd0) begin errors++; $display("FAIL addhl_sel got %h want 0", c_sel); end
    checks++; if (c_data !== 16'h1000) begin errors++; $display("FAIL addhl_data got %h want 1000", c_data); end
    checks++; if (c_mask !== 4'b0111) begin errors++; $display("FAIL addhl_mask got %b want 0111", c_mask); end
    checks++; if (c_val[2:0] !== 3'b010) begin errors++; $display("FAIL addhl_val got %b want 010", c_val[2:0]); end
    checks++; if (c_fwe !== 1'b1) begin errors++; $display("FAIL addhl_fwe got %b want 1", c_fwe); end
    clk1(1'b0, 1'b0);
    checks++; if (busy !== 1'b0 || n_done !== 1) begin errors++; $display("FAIL addhl_end got busy=%b n=%0d want 0/1", busy, n_done); end
  endtask

  task automatic test_add_hl_carry();
    clr();
    issue(3'd0, 16'h8000, 16'h8000, 16'h0, 1'b0);
    clk1(1'b1, 1'b0);
    checks++; if (c_data !== 16'h0000) begin errors++; $display("FAIL addhlc_data got %h want 0000", c_data); end
    checks++; if (c_val[2:0] !== 3'b001) begin errors++; $display("FAIL addhlc_val got %b want 001", c_val[2:0]); end
    checks++; if (c_mask[3] !== 1'b0) begin errors++; $display("FAIL addhlc_zmask got %b want 0", c_mask[3]); end
    clk1(1'b0, 1'b0);
  endtask

  task automatic test_add_sp_wait();
    clr();
    imm8 = 8'h01;
    issue(3'd3, 16'h0, 16'h0, 16'h00FF, 1'b0);
    clk1(1'b1, 1'b0);
    clk1(1'b1, 1'b0);
    checks++; if (busy !== 1'b1 || n_done !== 0) begin errors++; $display("FAIL addsp_wait got busy=%b n=%0d want 1/0", busy, n_done); end
    clk1(1'b1, 1'b1);
    checks++; if (add_ctrl !== 1'b0) begin errors++; $display("FAIL addsp_ctrl got %b want 0", add_ctrl); end
    checks++; if (add_b !== 16'h0001) begin errors++; $display("FAIL addsp_b got %h want 0001", add_b); end
    clk1(1'b0, 1'b0);
    clk1(1'b1, 1'b0);
    checks++; if (n_done !== 0) begin errors++; $display("FAIL addsp_early got %0d want 0", n_done); end
    clk1(1'b1, 1'b0);
    checks++; if (n_done !== 1) begin errors++; $display("FAIL addsp_done got %0d want 1", n_done); end
    checks++; if (c_data !== 16'h0100) begin errors++; $display("FAIL addsp_data got %h want 0100", c_data); end
    checks++; if (c_val !== 4'b0011) begin errors++; $display("FAIL addsp_val got %b want 0011", c_val); end
    checks++; if (c_mask !== 4'b1111) begin errors++; $display("FAIL addsp_mask got %b want 1111", c_mask); end
    checks++; if (c_sel !== 2'd1) begin errors++; $display("FAIL addsp_sel got %h want 1", c_sel); end
    clk1(1'b0, 1'b0);
    checks++; if (add_a !== 16'h00FF) begin errors++; $display("FAIL addsp_hold got %h want 00FF", add_a); end
  endtask

  task automatic test_back_to_back();
    clr();
    issue(3'd2, 16'h0000, 16'h0, 16'h0, 1'b0);
    issue(3'd1, 16'h0005, 16'h0, 16'h0, 1'b0);
    clk1(1'b1, 1'b0);
    checks++; if (c_data !== 16'hFFFF) begin errors++; $display("FAIL dec_data got %h want FFFF", c_data); end
    checks++; if (c_sel !== 2'd2) begin errors++; $display("FAIL dec_sel got %h want 2", c_sel); end
    checks++; if (n_fw !== 0) begin errors++; $display("FAIL dec_fwe got %0d want 0", n_fw); end
    clk1(1'b0, 1'b0);
    checks++; if (busy !== 1'b0 || n_done !== 1) begin errors++; $display("FAIL dec_end got busy=%b n=%0d want 0/1", busy, n_done); end
    clr();
    issue(3'd1, 16'hFFFF, 16'h0, 16'h0, 1'b1);
    clk1(1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || n_done !== 0) begin errors++; $display("FAIL inc_coinc got busy=%b n=%0d want 1/0", busy, n_done); end
    clk1(1'b1, 1'b0);
    checks++; if (c_data !== 16'h0000) begin errors++; $display("FAIL inc_data got %h want 0000", c_data); end
    checks++; if (n_fw !== 0 || n_done !== 1) begin errors++; $display("FAIL inc_fwe got fw=%0d n=%0d want 0/1", n_fw, n_done); end
    clk1(1'b0, 1'b0);
  endtask

  task automatic test_reserved();
    issue(3'd5, 16'h1, 16'h1, 16'h1, 1'b0);
    clk1(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reserved_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    clr();
    imm8 = 8'h10;
    issue(3'd3, 16'h0, 16'h0, 16'h1234, 1'b0);
    clk1(1'b1, 1'b1);
    clk1(1'b1, 1'b0);
    m_tick = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    @(posedge clk);
    sample();
    @(negedge clk);
    reset_n = 1'b1;
    clk1(1'b1, 1'b0);
    clk1(1'b1, 1'b0);
    checks++; if (n_wb !== 0 || n_fw !== 0) begin errors++; $display("FAIL abort_wb got wb=%0d fw=%0d want 0/0", n_wb, n_fw); end
    clr();
    imm8 = 8'hFF;
    issue(3'd4, 16'h0, 16'h0, 16'h0000, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld_busy got %b want 1", busy); end
    clk1(1'b1, 1'b1);
    checks++; if (n_done !== 0) begin errors++; $display("FAIL ld_early got %0d want 0", n_done); end
    clk1(1'b1, 1'b0);
    checks++; if (n_done !== 1) begin errors++; $display("FAIL ld_done got %0d want 1", n_done); end
    checks++; if (c_data !== 16'hFFFF) begin errors++; $display("FAIL ld_data got %h want FFFF", c_data); end
    checks++; if (c_sel !== 2'd0) begin errors++; $display("FAIL ld_sel got %h want 0", c_sel); end
    checks++; if (c_val !== 4'b0000) begin errors++; $display("FAIL ld_val got %b want 0000", c_val); end
    checks++; if (c_mask !== 4'b1111) begin errors++; $display("FAIL ld_mask got %b want 1111", c_mask); end
    clk1(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add_hl_half();
    test_add_hl_carry();
    test_add_sp_wait();
    test_back_to_back();
    test_reserved();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
